// File: rtl/game_flow_controller_pkg.sv
// Shared state encodings and default timing constants for the Frogger game flow controller.
package game_flow_controller_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARMED       = 3'd1,
        RUNNING     = 3'd2,
        DYING       = 3'd3,
        LEVEL_PAUSE = 3'd4,
        GAME_OVER   = 3'd5
    } state_t;

    localparam int unsigned C_START_LIVES  = 3;
    localparam int unsigned C_DEATH_FRAMES = 60;
    localparam int unsigned C_LEVEL_FRAMES = 30;
    localparam int unsigned C_OVER_FRAMES  = 120;
    localparam int unsigned C_BLINK_FRAMES = 8;

    // Thermometer code: bit k set when lives > k.
    function automatic logic [2:0] lives_to_leds(input logic [1:0] lives);
        return {lives > 2'd2, lives > 2'd1, lives > 2'd0};
    endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Switch/collision inputs and gating outputs of the game flow controller.
interface game_flow_controller_if;
    logic       i_Frame_Tick;
    logic       i_All_Switch;
    logic       i_Any_Switch;
    logic       i_Has_Collided;
    logic       i_Level_Up;
    logic       o_Game_Active;
    logic       o_Freeze;
    logic       o_Respawn;
    logic       o_Frog_Blink;
    logic [1:0] o_Lives;
    logic [2:0] o_Life_LEDs;
    logic [2:0] o_State;

    modport master (
        output i_Frame_Tick, i_All_Switch, i_Any_Switch, i_Has_Collided, i_Level_Up,
        input  o_Game_Active, o_Freeze, o_Respawn, o_Frog_Blink, o_Lives, o_Life_LEDs, o_State
    );

    modport slave (
        input  i_Frame_Tick, i_All_Switch, i_Any_Switch, i_Has_Collided, i_Level_Up,
        output o_Game_Active, o_Freeze, o_Respawn, o_Frog_Blink, o_Lives, o_Life_LEDs, o_State
    );
endinterface

// File: rtl/game_flow_controller_frame_timer.sv
// 8-bit frame tick counter with synchronous clear and terminal count at limit-1.
module game_flow_controller_frame_timer (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Clear,
    input  logic       i_Enable,
    input  logic [7:0] i_Limit,
    output logic [7:0] o_Count,
    output logic       o_Terminal
);

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            o_Count <= '0;
        else if (i_Clear)
            o_Count <= '0;
        else if (i_Enable)
            o_Count <= o_Count + 8'd1;
    end

    assign o_Terminal = i_Enable && (o_Count == i_Limit - 8'd1);

endmodule

// File: rtl/game_flow_controller.sv
// Frame-timed Frogger game sequencer: start, play, death pause, level pause, game over.
// Optional feature macro: FROGGER_EXTRA_LIFE_EN (extra life every fourth level-up).
module game_flow_controller #(
    parameter int unsigned C_START_LIVES  = game_flow_controller_pkg::C_START_LIVES,
    parameter int unsigned C_DEATH_FRAMES = game_flow_controller_pkg::C_DEATH_FRAMES,
    parameter int unsigned C_LEVEL_FRAMES = game_flow_controller_pkg::C_LEVEL_FRAMES,
    parameter int unsigned C_OVER_FRAMES  = game_flow_controller_pkg::C_OVER_FRAMES,
    parameter int unsigned C_BLINK_FRAMES = game_flow_controller_pkg::C_BLINK_FRAMES
) (
    input logic                   i_Clk,
    input logic                   i_Reset,
    game_flow_controller_if.slave ifc
);
    import game_flow_controller_pkg::*;

    if (C_START_LIVES < 1 || C_START_LIVES > 3) begin : g_bad_lives
        $error("C_START_LIVES must be 1..3");
    end
    if (C_DEATH_FRAMES < 1 || C_DEATH_FRAMES > 255 || C_LEVEL_FRAMES < 1 || C_LEVEL_FRAMES > 255 ||
        C_OVER_FRAMES < 1 || C_OVER_FRAMES > 255 || C_BLINK_FRAMES < 1 || C_BLINK_FRAMES > 255) begin : g_bad_frames
        $error("frame parameters must be 1..255");
    end

    state_t     state, state_n;
    logic [1:0] lives, lives_n;
    logic       blink, blink_n;
    logic       respawn, respawn_n;
    logic       active, freeze;
    logic [2:0] leds;
    logic       coll_q, lvl_q, coll_ev, lvl_ev;
    logic [7:0] limit, count;
    logic       term, blink_toggle;

`ifdef FROGGER_EXTRA_LIFE_EN
    logic [1:0] level_cnt, level_cnt_n;
`endif

    assign coll_ev = ifc.i_Has_Collided & ~coll_q;
    assign lvl_ev  = ifc.i_Level_Up & ~lvl_q;

    always_comb begin
        case (state)
            DYING:       limit = 8'(C_DEATH_FRAMES);
            LEVEL_PAUSE: limit = 8'(C_LEVEL_FRAMES);
            GAME_OVER:   limit = 8'(C_OVER_FRAMES);
            default:     limit = '0;
        endcase
    end

    // Timer restarts on every state change, including 6/7 recovery.
    game_flow_controller_frame_timer u_frame_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Clear    (state_n != state),
        .i_Enable   (ifc.i_Frame_Tick),
        .i_Limit    (limit),
        .o_Count    (count),
        .o_Terminal (term)
    );

    assign blink_toggle = ifc.i_Frame_Tick &&
                          ((({1'b0, count} + 9'd1) % 9'(C_BLINK_FRAMES)) == 9'd0);

    always_comb begin
        state_n   = state;
        lives_n   = lives;
        blink_n   = 1'b0;
        respawn_n = 1'b0;
`ifdef FROGGER_EXTRA_LIFE_EN
        level_cnt_n = level_cnt;
`endif
        case (state)
            IDLE: begin
                if (ifc.i_All_Switch) begin
                    state_n = ARMED;
                    lives_n = 2'(C_START_LIVES);
`ifdef FROGGER_EXTRA_LIFE_EN
                    level_cnt_n = '0;
`endif
                end
            end
            ARMED: begin
                if (!ifc.i_Any_Switch) begin
                    state_n   = RUNNING;
                    respawn_n = 1'b1;
                end
            end
            RUNNING: begin
                if (coll_ev) begin
                    lives_n = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    state_n = (lives <= 2'd1) ? GAME_OVER : DYING;
                    blink_n = 1'b1;
                end else if (lvl_ev) begin
                    state_n = LEVEL_PAUSE;
`ifdef FROGGER_EXTRA_LIFE_EN
                    level_cnt_n = level_cnt + 2'd1;
                    if (level_cnt == 2'd3 && lives != 2'd3)
                        lives_n = lives + 2'd1;
`endif
                end
            end
            DYING: begin
                blink_n = blink_toggle ? ~blink : blink;
                if (term) begin
                    state_n   = RUNNING;
                    respawn_n = 1'b1;
                    blink_n   = 1'b0;
                end
            end
            LEVEL_PAUSE: begin
                if (term)
                    state_n = RUNNING;
            end
            GAME_OVER: begin
                blink_n = 1'b1;
                if (term) begin
                    state_n = IDLE;
                    blink_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state   <= IDLE;
            lives   <= '0;
            blink   <= 1'b0;
            respawn <= 1'b0;
            active  <= 1'b0;
            freeze  <= 1'b0;
            leds    <= '0;
            coll_q  <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state   <= state_n;
            lives   <= lives_n;
            blink   <= blink_n;
            respawn <= respawn_n;
            active  <= (state_n == RUNNING);
            freeze  <= (state_n == DYING) || (state_n == LEVEL_PAUSE) || (state_n == GAME_OVER);
            leds    <= lives_to_leds(lives_n);
            coll_q  <= ifc.i_Has_Collided;
            lvl_q   <= ifc.i_Level_Up;
        end
    end

`ifdef FROGGER_EXTRA_LIFE_EN
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset)
            level_cnt <= '0;
        else
            level_cnt <= level_cnt_n;
    end
`endif

    assign ifc.o_State       = state;
    assign ifc.o_Lives       = lives;
    assign ifc.o_Life_LEDs   = leds;
    assign ifc.o_Frog_Blink  = blink;
    assign ifc.o_Respawn     = respawn;
    assign ifc.o_Game_Active = active;
    assign ifc.o_Freeze      = freeze;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed self-checking bench for game_flow_controller with hand-computed expectations.
module tb_game_flow_controller;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned exp_lives;

    game_flow_controller_if ifc();

    game_flow_controller dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .ifc     (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ifc.i_Frame_Tick = 1'b1;
            step();
            ifc.i_Frame_Tick = 1'b0;
            step();
        end
    endtask

    task automatic start_game();
        ifc.i_All_Switch = 1'b1;
        ifc.i_Any_Switch = 1'b1;
        repeat (5) step();
        ifc.i_All_Switch = 1'b0;
        ifc.i_Any_Switch = 1'b0;
        step();
    endtask

    // Single collision from RUNNING followed by the full death pause.
    task automatic die_and_respawn();
        ifc.i_Has_Collided = 1'b1;
        step();
        ifc.i_Has_Collided = 1'b0;
        do_ticks(C_DEATH - 1);
        ifc.i_Frame_Tick = 1'b1;
        step();
        ifc.i_Frame_Tick = 1'b0;
        step();
    endtask

    localparam int unsigned C_DEATH = 60;
    localparam int unsigned C_LEVEL = 30;
    localparam int unsigned C_OVER  = 120;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        ifc.i_Frame_Tick   = 1'b0;
        ifc.i_All_Switch   = 1'b0;
        ifc.i_Any_Switch   = 1'b0;
        ifc.i_Has_Collided = 1'b0;
        ifc.i_Level_Up     = 1'b0;
        #2 rst = 1'b1;
        #2;
        check("rst_state", 32'(ifc.o_State), 0);
        check("rst_lives", 32'(ifc.o_Lives), 0);
        check("rst_leds", 32'(ifc.o_Life_LEDs), 0);
        check("rst_outs", 32'({ifc.o_Game_Active, ifc.o_Freeze, ifc.o_Respawn, ifc.o_Frog_Blink}), 0);
        step();
        rst = 1'b0;
        step();

        // Start chord, then release.
        ifc.i_All_Switch = 1'b1;
        ifc.i_Any_Switch = 1'b1;
        step();
        check("armed_state", 32'(ifc.o_State), 1);
        check("armed_lives", 32'(ifc.o_Lives), 3);
        check("armed_leds", 32'(ifc.o_Life_LEDs), 7);
        repeat (4) step();
        check("armed_hold", 32'(ifc.o_State), 1);
        check("armed_respawn", 32'(ifc.o_Respawn), 0);
        ifc.i_All_Switch = 1'b0;
        ifc.i_Any_Switch = 1'b0;
        step();
        check("run_state", 32'(ifc.o_State), 2);
        check("run_respawn", 32'(ifc.o_Respawn), 1);
        check("run_active", 32'(ifc.o_Game_Active), 1);
        step();
        check("respawn_one_clk", 32'(ifc.o_Respawn), 0);

        // Collision held high well over 100 clocks.
        ifc.i_Has_Collided = 1'b1;
        step();
        check("dying_state", 32'(ifc.o_State), 3);
        check("dying_lives", 32'(ifc.o_Lives), 2);
        check("dying_leds", 32'(ifc.o_Life_LEDs), 3);
        check("dying_freeze", 32'(ifc.o_Freeze), 1);
        check("dying_blink0", 32'(ifc.o_Frog_Blink), 1);
        check("dying_active", 32'(ifc.o_Game_Active), 0);
        for (int unsigned k = 1; k < C_DEATH; k++) begin
            ifc.i_Frame_Tick = 1'b1;
            if (k == 20) ifc.i_Level_Up = 1'b1;
            step();
            ifc.i_Frame_Tick = 1'b0;
            step();
            ifc.i_Level_Up = 1'b0;
            if (k == 7)  check("blink_t7", 32'(ifc.o_Frog_Blink), 1);
            if (k == 8)  check("blink_t8", 32'(ifc.o_Frog_Blink), 0);
            if (k == 16) check("blink_t16", 32'(ifc.o_Frog_Blink), 1);
            if (k == 59) begin
                check("blink_t59", 32'(ifc.o_Frog_Blink), 0);
                check("dying_t59", 32'(ifc.o_State), 3);
            end
        end
        ifc.i_Frame_Tick = 1'b1;
        step();
        check("respawn_state", 32'(ifc.o_State), 2);
        check("respawn_pulse", 32'(ifc.o_Respawn), 1);
        check("respawn_blink", 32'(ifc.o_Frog_Blink), 0);
        check("respawn_freeze", 32'(ifc.o_Freeze), 0);
        ifc.i_Frame_Tick = 1'b0;
        step();
        check("held_coll_lives", 32'(ifc.o_Lives), 2);
        check("held_coll_state", 32'(ifc.o_State), 2);
        ifc.i_Has_Collided = 1'b0;
        step();

        // Four level-ups, each a full pause without respawn.
        exp_lives = 2;
        for (int unsigned j = 1; j <= 4; j++) begin
            ifc.i_Level_Up = 1'b1;
            step();
            ifc.i_Level_Up = 1'b0;
            if (j == 1) begin
                check("lvl_state", 32'(ifc.o_State), 4);
                check("lvl_freeze", 32'(ifc.o_Freeze), 1);
            end
            do_ticks(C_LEVEL - 1);
            if (j == 1) check("lvl_t29", 32'(ifc.o_State), 4);
            ifc.i_Frame_Tick = 1'b1;
            step();
            if (j == 1) begin
                check("lvl_exit_state", 32'(ifc.o_State), 2);
                check("lvl_no_respawn", 32'(ifc.o_Respawn), 0);
            end
            ifc.i_Frame_Tick = 1'b0;
            step();
`ifdef FROGGER_EXTRA_LIFE_EN
            if (j == 4) exp_lives = 3;
`endif
            check("lvl_lives", 32'(ifc.o_Lives), exp_lives);
        end

        // Collision and level-up rising together: collision wins.
        ifc.i_Has_Collided = 1'b1;
        ifc.i_Level_Up     = 1'b1;
        step();
        ifc.i_Has_Collided = 1'b0;
        ifc.i_Level_Up     = 1'b0;
        exp_lives--;
        check("both_state", 32'(ifc.o_State), 3);
        check("both_lives", 32'(ifc.o_Lives), exp_lives);
        do_ticks(C_DEATH - 1);
        ifc.i_Frame_Tick = 1'b1;
        step();
        ifc.i_Frame_Tick = 1'b0;
        step();
        check("both_back_run", 32'(ifc.o_State), 2);

        while (exp_lives > 1) begin
            die_and_respawn();
            exp_lives--;
            check("extra_death_lives", 32'(ifc.o_Lives), exp_lives);
        end

        // Last life lost: game over, switches ignored.
        ifc.i_Has_Collided = 1'b1;
        step();
        ifc.i_Has_Collided = 1'b0;
        check("over_state", 32'(ifc.o_State), 5);
        check("over_lives", 32'(ifc.o_Lives), 0);
        check("over_leds", 32'(ifc.o_Life_LEDs), 0);
        check("over_blink", 32'(ifc.o_Frog_Blink), 1);
        check("over_freeze", 32'(ifc.o_Freeze), 1);
        ifc.i_All_Switch = 1'b1;
        ifc.i_Any_Switch = 1'b1;
        do_ticks(C_OVER - 1);
        check("over_t119", 32'(ifc.o_State), 5);
        ifc.i_Frame_Tick = 1'b1;
        step();
        check("idle_state", 32'(ifc.o_State), 0);
        check("idle_leds", 32'(ifc.o_Life_LEDs), 0);
        check("idle_outs", 32'({ifc.o_Freeze, ifc.o_Frog_Blink, ifc.o_Game_Active}), 0);
        ifc.i_Frame_Tick = 1'b0;
        ifc.i_All_Switch = 1'b0;
        ifc.i_Any_Switch = 1'b0;
        step();
        check("idle_hold", 32'(ifc.o_State), 0);

        // Asynchronous reset in RUNNING with two lives.
        start_game();
        die_and_respawn();
        check("pre_rst_lives", 32'(ifc.o_Lives), 2);
        check("pre_rst_state", 32'(ifc.o_State), 2);
        rst = 1'b1;
        #1;
        check("arst_state", 32'(ifc.o_State), 0);
        check("arst_lives", 32'(ifc.o_Lives), 0);
        check("arst_leds", 32'(ifc.o_Life_LEDs), 0);
        check("arst_active", 32'(ifc.o_Game_Active), 0);
        step();
        check("arst_respawn", 32'(ifc.o_Respawn), 0);
        rst = 1'b0;
        step();
        check("post_rst_state", 32'(ifc.o_State), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
